// File: rtl/win_acc_8.sv
// win_acc_8: packet accumulator for sign-magnitude products.
// Sums each packet into a saturating two's-complement accumulator and
// presents the full-precision sum, an 8-bit sign-magnitude quantized sum
// and the beat count once the last beat of the packet has been accepted.
module win_acc_8 #(
    parameter int unsigned ACC_W = 20,
    parameter int unsigned SHIFT = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      prod_in,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [7:0]       q_out,
    output logic [7:0]       beat_cnt
);

    localparam int unsigned SUM_W = ACC_W + 1;
    // Symmetric saturation limits; the most negative code is never produced.
    localparam logic signed [SUM_W-1:0] SUM_MAX = $signed({2'b00, {(ACC_W-1){1'b1}}});
    localparam logic signed [SUM_W-1:0] SUM_MIN = -SUM_MAX;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_nxt;
    logic signed [ACC_W-1:0] acc_sat;
    logic signed [ACC_W-1:0] prod_tc;
    logic signed [SUM_W-1:0] sum;
    logic [ACC_W-1:0]        mag;
    logic [ACC_W-1:0]        mag_sh;
    logic [6:0]              qmag;
    logic [7:0]              q_nxt;
    logic [7:0]              cnt_nxt;
    logic                    q_upd;
    logic                    beat;

    // Ready whenever not holding a result; low throughout reset.
    assign in_ready = rst_n & (state != S_OUT);
    assign beat     = in_valid & in_ready;
    assign acc_out  = acc;

    // Sign-magnitude to two's complement, then saturating add.
    always_comb begin
        prod_tc = $signed(ACC_W'(prod_in[14:0]));
        if (prod_in[15]) begin
            prod_tc = -prod_tc;
        end
        sum = SUM_W'(acc) + SUM_W'(prod_tc);
        if (sum > SUM_MAX) begin
            acc_sat = ACC_W'(SUM_MAX);
        end else if (sum < SUM_MIN) begin
            acc_sat = ACC_W'(SUM_MIN);
        end else begin
            acc_sat = ACC_W'(sum);
        end
    end

    // Quantize the next accumulator value to 8-bit sign-magnitude.
    always_comb begin
        mag    = acc_nxt[ACC_W-1] ? ACC_W'(-acc_nxt) : ACC_W'(acc_nxt);
        mag_sh = mag >> SHIFT;
        qmag   = (mag_sh > ACC_W'(127)) ? 7'h7F : mag_sh[6:0];
        q_nxt  = {acc_nxt[ACC_W-1] & (qmag != 7'd0), qmag};
    end

    // Next-state and datapath control.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = beat_cnt;
        q_upd     = 1'b0;
        case (state)
            S_IDLE: begin
                if (beat) begin
                    acc_nxt   = prod_tc;
                    cnt_nxt   = 8'd1;
                    q_upd     = in_last;
                    state_nxt = in_last ? S_OUT : S_ACC;
                end
            end
            S_ACC: begin
                if (beat) begin
                    acc_nxt   = acc_sat;
                    cnt_nxt   = (beat_cnt == 8'hFF) ? beat_cnt : beat_cnt + 8'd1;
                    q_upd     = in_last;
                    state_nxt = in_last ? S_OUT : S_ACC;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Accumulator, count, quantized output and valid registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            beat_cnt  <= 8'd0;
            q_out     <= 8'd0;
            out_valid <= 1'b0;
        end else begin
            acc       <= acc_nxt;
            beat_cnt  <= cnt_nxt;
            out_valid <= (state_nxt == S_OUT);
            if (q_upd) begin
                q_out <= q_nxt;
            end
        end
    end

endmodule

// File: tb/tb_win_acc_8.sv
// Testbench for win_acc_8: scoreboard of expected packet results built by a
// behavioural model, checked by an independent output monitor.
module tb_win_acc_8;

    localparam int unsigned ACC_W = 20;
    localparam int unsigned SHIFT = 6;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [15:0]      prod_in;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
    logic [7:0]       q_out;
    logic [7:0]       beat_cnt;

    typedef struct packed {
        logic [ACC_W-1:0] acc;
        logic [7:0]       q;
        logic [7:0]       cnt;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] pkt[$];
    int          errors = 0;
    int          checks = 0;
    int          rdy_mode = 0;
    exp_t        mon_e;

    win_acc_8 #(.ACC_W(ACC_W), .SHIFT(SHIFT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .prod_in   (prod_in),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .q_out     (q_out),
        .beat_cnt  (beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: integer sum clamped to +/-(2^(ACC_W-1)-1), then |sum|/2^SHIFT capped at 127.
    function automatic exp_t model_pkt();
        exp_t   e;
        longint mx;
        longint s;
        longint v;
        longint a;
        longint m;
        mx = (longint'(1) << (ACC_W - 1)) - 1;
        s  = 0;
        foreach (pkt[i]) begin
            v = longint'(pkt[i][14:0]);
            if (pkt[i][15]) v = -v;
            s = s + v;
            if (s > mx)  s = mx;
            if (s < -mx) s = -mx;
        end
        a = (s < 0) ? -s : s;
        m = a / (longint'(1) << SHIFT);
        if (m > 127) m = 127;
        e.acc = ACC_W'(s);
        e.q   = {((s < 0) && (m != 0)) ? 1'b1 : 1'b0, m[6:0]};
        e.cnt = (pkt.size() > 255) ? 8'd255 : 8'(pkt.size());
        return e;
    endfunction

    // Present one beat until accepted; record it in the model on acceptance.
    task automatic beat(input logic [15:0] p, input logic last);
        logic ok;
        ok       = 1'b0;
        prod_in  = p;
        in_last  = last;
        in_valid = 1'b1;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: in_ready never 1 for prod 0x%0h", p);
        end else begin
            pkt.push_back(p);
            if (last) begin
                sb.push_back(model_pkt());
                pkt.delete();
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // out_ready driver: 0 = always ready, 1 = random, 2 = held low.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: compare every handshaken result against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: acc 0x%0h q 0x%0h with nothing expected", acc_out, q_out);
                end else begin
                    mon_e = sb.pop_front();
                    check("acc_out", 32'(acc_out), 32'(mon_e.acc));
                    check("q_out", 32'(q_out), 32'(mon_e.q));
                    check("beat_cnt", 32'(beat_cnt), 32'(mon_e.cnt));
                end
            end
        end
    end

    initial begin
        logic [15:0] p;
        int          len;
        int          budget;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        prod_in  = 16'h0000;

        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_acc_out", 32'(acc_out), 32'd0);
        check("rst_q_out", 32'(q_out), 32'd0);
        check("rst_beat_cnt", 32'(beat_cnt), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Three-beat packet, latency one cycle.
        beat(16'h1000, 1'b0);
        beat(16'h0800, 1'b0);
        beat(16'h8400, 1'b1);
        check("latency_out_valid", 32'(out_valid), 32'd1);

        // Single-beat packets: quantizer saturation, negative zero cases.
        beat(16'hC000, 1'b1);
        beat(16'h8000, 1'b1);
        beat(16'h8020, 1'b1);

        // Accumulator saturation.
        for (int i = 0; i < 16; i++) beat(16'h7FFF, 1'b0);
        beat(16'h7FFF, 1'b1);

        // Back-pressure: outputs held stable, in_ready low.
        idle(2);
        rdy_mode = 2;
        idle(1);
        beat(16'h0123, 1'b0);
        beat(16'h8456, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            if (sb.size() != 0) begin
                check("hold_acc_out", 32'(acc_out), 32'(sb[0].acc));
                check("hold_q_out", 32'(q_out), 32'(sb[0].q));
                check("hold_beat_cnt", 32'(beat_cnt), 32'(sb[0].cnt));
            end
            idle(1);
        end
        rdy_mode = 0;
        budget = 0;
        while (out_valid && budget < 20) begin
            idle(1);
            budget++;
        end
        check("release_out_valid", 32'(out_valid), 32'd0);
        check("release_in_ready", 32'(in_ready), 32'd1);
        beat(16'h0005, 1'b0);
        check("restart_beat_cnt", 32'(beat_cnt), 32'd1);
        beat(16'h0003, 1'b1);

        // Mid-packet asynchronous reset discards the partial packet.
        idle(2);
        beat(16'h0100, 1'b0);
        beat(16'h0200, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_acc_out", 32'(acc_out), 32'd0);
        check("mid_rst_q_out", 32'(q_out), 32'd0);
        check("mid_rst_beat_cnt", 32'(beat_cnt), 32'd0);
        pkt.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        beat(16'h0040, 1'b1);

        // Randomized packets with gaps and random back-pressure.
        idle(2);
        rdy_mode = 1;
        for (int j = 0; j < 40; j++) begin
            len = (j % 8 == 0) ? 20 : int'($urandom_range(1, 6));
            for (int i = 0; i < len; i++) begin
                if (j % 8 == 0)
                    p = {1'(j % 16 == 0), 15'h7000 | 15'($urandom_range(0, 4095))};
                else
                    p = 16'($urandom);
                beat(p, 1'(i == len - 1));
                if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
            end
        end

        rdy_mode = 0;
        budget = 0;
        while (sb.size() != 0 && budget < 100) begin
            idle(1);
            budget++;
        end
        check("drain_scoreboard_empty", 32'(sb.size()), 32'd0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/win_acc_8.md
WIN_ACC_8 -- requirements
Module: win_acc_8

Interface
REQ-001 Parameter ACC_W, default 20, sets the accumulator width as two's complement, legal range 17..32.
REQ-002 Parameter SHIFT, default 6, sets the right shift applied to the accumulator magnitude before 8-bit output, legal range 0..(ACC_W-2).
REQ-003 Port clk, input, 1 bit, is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1 bit, is the asynchronous active-low reset.
REQ-005 Port prod_in, input, 16 bits, is a sign-magnitude product: bit15 is the sign and [14:0] is the magnitude.
REQ-006 Port in_valid, input, 1 bit, SHALL mark prod_in as valid.
REQ-007 Port in_last, input, 1 bit, SHALL mark the final product of a packet and is qualified by in_valid.
REQ-008 Port in_ready, output, 1 bit, SHALL indicate that the block accepts a product this cycle.
REQ-009 Port out_valid, output, 1 bit, SHALL indicate that the result outputs are valid.
REQ-010 Port out_ready, input, 1 bit, SHALL indicate that downstream accepts the result.
REQ-011 Port acc_out, output, ACC_W bits, SHALL carry the full-precision two's-complement packet sum.
REQ-012 Port q_out, output, 8 bits, SHALL carry the sign-magnitude quantized sum: bit7 is the sign and [6:0] is the magnitude.
REQ-013 Port beat_cnt, output, 8 bits, SHALL carry the number of products accepted in the current or just-finished packet, saturating at 255.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, ACC and OUT.
REQ-015 in_ready SHALL be 1 in IDLE and ACC, and 0 in OUT; there is no bypass.
REQ-016 A beat transfers when in_valid and in_ready are both 1 on a rising edge.
REQ-017 Each accepted prod_in SHALL be converted to two's complement: the magnitude [14:0] is zero-extended to ACC_W and negated when bit15=1; 0x8000 converts to 0.
REQ-018 A beat accepted in IDLE SHALL load the accumulator with the converted product (no add) and set beat_cnt=1.
REQ-019 A beat accepted in ACC SHALL add the converted product to the accumulator and increment beat_cnt.
REQ-020 The accumulation SHALL saturate to +(2^(ACC_W-1)-1) or -(2^(ACC_W-1)-1) and SHALL never wrap.
REQ-021 IDLE->ACC SHALL occur on an accepted beat with in_last=0.
REQ-022 IDLE->OUT or ACC->OUT SHALL occur on an accepted beat with in_last=1; a single-beat packet is legal.
REQ-023 out_valid SHALL assert in the cycle after the last beat is accepted (latency 1), with acc_out and q_out already updated to include that beat.
REQ-024 In OUT, out_valid, acc_out, q_out and beat_cnt SHALL hold stable until out_ready=1.
REQ-025 On the edge where out_valid=1 and out_ready=1, the FSM SHALL return to IDLE and out_valid SHALL deassert; the accumulator value is retained but ignored.
REQ-026 q_out magnitude SHALL equal min(|acc| >> SHIFT, 127), truncating toward zero.
REQ-027 q_out sign SHALL equal acc<0, but SHALL be forced to 0 when the magnitude is 0, so negative zero is never emitted.
REQ-028 q_out SHALL be registered and SHALL change only on the last-beat update.
REQ-029 in_valid=0 in ACC SHALL hold all state; packets may contain gaps.
REQ-030 in_last, prod_in and in_valid SHALL be ignored while in_ready=0.

Reset
REQ-031 rst_n=0 SHALL immediately (asynchronously) force: state=IDLE, accumulator=0, acc_out=0, q_out=0x00, beat_cnt=0, out_valid=0.
REQ-032 in_ready SHALL be 0 while rst_n=0, and 1 in the first cycle after release.
REQ-033 A reset asserted mid-packet or in OUT SHALL discard the partial or pending result; no out_valid SHALL follow for that packet.

Verification
REQ-034 Beats 0x1000, 0x0800, then 0x8400 with in_last, out_ready=1 -> one cycle later out_valid=1, acc_out=5120, q_out=0x50, beat_cnt=3.
REQ-035 Single beat 0xC000 with in_last -> acc_out=-16384, q_out=0xFF (saturated), beat_cnt=1; single beat 0x8000 -> acc_out=0, q_out=0x00; single beat 0x8020 -> acc_out=-32, q_out=0x00.
REQ-036 17 beats of 0x7FFF (ACC_W=20) -> acc_out=0x7FFFF (saturated), q_out=0x7F, beat_cnt=17.
REQ-037 out_ready held 0 for 5 cycles after out_valid -> outputs stable and in_ready=0 throughout; out_ready=1 -> IDLE next cycle, and a new packet is accepted with beat_cnt restarting at 1.
REQ-038 rst_n pulsed low after 2 of 4 beats -> all outputs 0 asynchronously; a following packet 0x0040 with in_last -> q_out=0x01, beat_cnt=1.
